// File: rtl/kb_scan_to_ascii_fifo.sv
// PS/2 set-2 scan-code to ASCII converter with a first-word-fall-through
// output FIFO. The converter tracks the F0/E0 prefixes and the state of
// shift, ctrl and caps lock. It registers each lookup result and then
// pushes the character into the FIFO that feeds the text/display path.
module kb_scan_to_ascii_fifo #(
  parameter int FIFO_DEPTH   = 16,
  parameter bit CAPS_SYMBOLS = 1'b0,
  parameter bit CTRL_EN      = 1'b1,
  localparam int CW = $clog2(FIFO_DEPTH + 1),
  localparam int PW = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scan_valid,
  input  logic [7:0]    scan_code,
  input  logic          ascii_ready,
  input  logic          clear_overflow,
  output logic          ascii_valid,
  output logic [7:0]    ascii_data,
  output logic [CW-1:0] fifo_count,
  output logic          overflow,
  output logic          shift_state,
  output logic          ctrl_state,
  output logic          caps_state
);

  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_LSHFT = 8'h12;
  localparam logic [7:0] CODE_RSHFT = 8'h59;
  localparam logic [7:0] CODE_CTRL  = 8'h14;
  localparam logic [7:0] CODE_CAPS  = 8'h58;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } state_e;

  // One entry of the non-extended character map.
  typedef struct packed {
    logic       hit;      // code produces a character
    logic       letter;   // shift XOR caps selects case; ctrl applies
    logic       symbol;   // digit/punctuation: shift (optionally caps) selects
    logic [7:0] base;     // unshifted character
    logic [7:0] shifted;  // shifted character
  } map_t;

  // US-layout set-2 character map for non-extended make codes.
  function automatic map_t lookup(input logic [7:0] code);
    map_t m;
    m = '0;
    case (code)
      // Letters
      8'h1C: m = '{1'b1, 1'b1, 1'b0, 8'h61, 8'h41};  // a
      8'h32: m = '{1'b1, 1'b1, 1'b0, 8'h62, 8'h42};  // b
      8'h21: m = '{1'b1, 1'b1, 1'b0, 8'h63, 8'h43};  // c
      8'h23: m = '{1'b1, 1'b1, 1'b0, 8'h64, 8'h44};  // d
      8'h24: m = '{1'b1, 1'b1, 1'b0, 8'h65, 8'h45};  // e
      8'h2B: m = '{1'b1, 1'b1, 1'b0, 8'h66, 8'h46};  // f
      8'h34: m = '{1'b1, 1'b1, 1'b0, 8'h67, 8'h47};  // g
      8'h33: m = '{1'b1, 1'b1, 1'b0, 8'h68, 8'h48};  // h
      8'h43: m = '{1'b1, 1'b1, 1'b0, 8'h69, 8'h49};  // i
      8'h3B: m = '{1'b1, 1'b1, 1'b0, 8'h6A, 8'h4A};  // j
      8'h42: m = '{1'b1, 1'b1, 1'b0, 8'h6B, 8'h4B};  // k
      8'h4B: m = '{1'b1, 1'b1, 1'b0, 8'h6C, 8'h4C};  // l
      8'h3A: m = '{1'b1, 1'b1, 1'b0, 8'h6D, 8'h4D};  // m
      8'h31: m = '{1'b1, 1'b1, 1'b0, 8'h6E, 8'h4E};  // n
      8'h44: m = '{1'b1, 1'b1, 1'b0, 8'h6F, 8'h4F};  // o
      8'h4D: m = '{1'b1, 1'b1, 1'b0, 8'h70, 8'h50};  // p
      8'h15: m = '{1'b1, 1'b1, 1'b0, 8'h71, 8'h51};  // q
      8'h2D: m = '{1'b1, 1'b1, 1'b0, 8'h72, 8'h52};  // r
      8'h1B: m = '{1'b1, 1'b1, 1'b0, 8'h73, 8'h53};  // s
      8'h2C: m = '{1'b1, 1'b1, 1'b0, 8'h74, 8'h54};  // t
      8'h3C: m = '{1'b1, 1'b1, 1'b0, 8'h75, 8'h55};  // u
      8'h2A: m = '{1'b1, 1'b1, 1'b0, 8'h76, 8'h56};  // v
      8'h1D: m = '{1'b1, 1'b1, 1'b0, 8'h77, 8'h57};  // w
      8'h22: m = '{1'b1, 1'b1, 1'b0, 8'h78, 8'h58};  // x
      8'h35: m = '{1'b1, 1'b1, 1'b0, 8'h79, 8'h59};  // y
      8'h1A: m = '{1'b1, 1'b1, 1'b0, 8'h7A, 8'h5A};  // z
      // Digits and punctuation
      8'h16: m = '{1'b1, 1'b0, 1'b1, 8'h31, 8'h21};  // 1 !
      8'h1E: m = '{1'b1, 1'b0, 1'b1, 8'h32, 8'h40};  // 2 @
      8'h26: m = '{1'b1, 1'b0, 1'b1, 8'h33, 8'h23};  // 3 #
      8'h25: m = '{1'b1, 1'b0, 1'b1, 8'h34, 8'h24};  // 4 $
      8'h2E: m = '{1'b1, 1'b0, 1'b1, 8'h35, 8'h25};  // 5 %
      8'h36: m = '{1'b1, 1'b0, 1'b1, 8'h36, 8'h5E};  // 6 ^
      8'h3D: m = '{1'b1, 1'b0, 1'b1, 8'h37, 8'h26};  // 7 &
      8'h3E: m = '{1'b1, 1'b0, 1'b1, 8'h38, 8'h2A};  // 8 *
      8'h46: m = '{1'b1, 1'b0, 1'b1, 8'h39, 8'h28};  // 9 (
      8'h45: m = '{1'b1, 1'b0, 1'b1, 8'h30, 8'h29};  // 0 )
      8'h0E: m = '{1'b1, 1'b0, 1'b1, 8'h60, 8'h7E};  // ` ~
      8'h4E: m = '{1'b1, 1'b0, 1'b1, 8'h2D, 8'h5F};  // - _
      8'h55: m = '{1'b1, 1'b0, 1'b1, 8'h3D, 8'h2B};  // = +
      8'h54: m = '{1'b1, 1'b0, 1'b1, 8'h5B, 8'h7B};  // [ {
      8'h5B: m = '{1'b1, 1'b0, 1'b1, 8'h5D, 8'h7D};  // ] }
      8'h5D: m = '{1'b1, 1'b0, 1'b1, 8'h5C, 8'h7C};  // \ |
      8'h4C: m = '{1'b1, 1'b0, 1'b1, 8'h3B, 8'h3A};  // ; :
      8'h52: m = '{1'b1, 1'b0, 1'b1, 8'h27, 8'h22};  // ' "
      8'h41: m = '{1'b1, 1'b0, 1'b1, 8'h2C, 8'h3C};  // , <
      8'h49: m = '{1'b1, 1'b0, 1'b1, 8'h2E, 8'h3E};  // . >
      8'h4A: m = '{1'b1, 1'b0, 1'b1, 8'h2F, 8'h3F};  // / ?
      // Control keys, which ignore the modifiers
      8'h66: m = '{1'b1, 1'b0, 1'b0, 8'h08, 8'h08};  // backspace
      8'h0D: m = '{1'b1, 1'b0, 1'b0, 8'h09, 8'h09};  // tab
      8'h5A: m = '{1'b1, 1'b0, 1'b0, 8'h0A, 8'h0A};  // enter
      8'h29: m = '{1'b1, 1'b0, 1'b0, 8'h20, 8'h20};  // space
      8'h76: m = '{1'b1, 1'b0, 1'b0, 8'h1B, 8'h1B};  // escape
      default: m = '0;
    endcase
    return m;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_e        state_q, state_d;
  logic          lshift_q, lshift_d;
  logic          rshift_q, rshift_d;
  logic          lctrl_q, lctrl_d;
  logic          rctrl_q, rctrl_d;
  logic          caps_q, caps_d;
  logic          caps_held_q, caps_held_d;
  logic          char_valid_q, char_valid_d;
  logic [7:0]    char_q, char_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic          key_ev, key_ext, key_brk;
  map_t          key_map;
  logic          shift_any, ctrl_any;
  logic          fifo_full, fifo_pop, fifo_wr;

  assign key_map   = lookup(scan_code);
  assign shift_any = lshift_q | rshift_q;
  assign ctrl_any  = lctrl_q | rctrl_q;

  // Prefix FSM: classify each byte as prefix or key event (make/break, ext).
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d = state_q;
    key_ev  = 1'b0;
    key_ext = 1'b0;
    key_brk = 1'b0;
    if (scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_code == CODE_BRK)      state_d = ST_BRK;
          else if (scan_code == CODE_EXT) state_d = ST_EXT;
          else                            key_ev  = 1'b1;
        end
        ST_EXT: begin
          if (scan_code == CODE_BRK) begin
            state_d = ST_EXT_BRK;
          end else begin
            key_ev  = 1'b1;
            key_ext = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          key_ev  = 1'b1;
          key_brk = 1'b1;
          state_d = ST_IDLE;
        end
        default: begin  // ST_EXT_BRK
          key_ev  = 1'b1;
          key_ext = 1'b1;
          key_brk = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Key events: update the modifier state and produce the character to push.
  always_comb begin
    lshift_d     = lshift_q;
    rshift_d     = rshift_q;
    lctrl_d      = lctrl_q;
    rctrl_d      = rctrl_q;
    caps_d       = caps_q;
    caps_held_d  = caps_held_q;
    char_valid_d = 1'b0;
    char_d       = char_q;
    if (key_ev) begin
      if (!key_ext) begin
        case (scan_code)
          CODE_LSHFT: lshift_d = !key_brk;
          CODE_RSHFT: rshift_d = !key_brk;
          CODE_CTRL:  lctrl_d  = !key_brk;
          CODE_CAPS: begin
            // Typematic repeats keep caps_held set, so only the first make toggles.
            if (key_brk) begin
              caps_held_d = 1'b0;
            end else begin
              if (!caps_held_q) caps_d = !caps_q;
              caps_held_d = 1'b1;
            end
          end
          default: begin
            if (!key_brk && key_map.hit) begin
              char_valid_d = 1'b1;
              if (key_map.letter) begin
                if (CTRL_EN && ctrl_any)       char_d = key_map.shifted & 8'h1F;
                else if (shift_any ^ caps_q)   char_d = key_map.shifted;
                else                           char_d = key_map.base;
              end else if (key_map.symbol) begin
                if (shift_any || (CAPS_SYMBOLS && caps_q)) char_d = key_map.shifted;
                else                                      char_d = key_map.base;
              end else begin
                char_d = key_map.base;
              end
            end
          end
        endcase
      end else begin
        case (scan_code)
          CODE_CTRL: rctrl_d = !key_brk;
          8'h5A: begin
            if (!key_brk) begin
              char_valid_d = 1'b1;
              char_d       = 8'h0A;
            end
          end
          8'h4A: begin
            if (!key_brk) begin
              char_valid_d = 1'b1;
              char_d       = 8'h2F;
            end
          end
          default: ;  // other extended keys are dropped
        endcase
      end
    end
  end

  // FIFO control: push the registered character; a push into a full FIFO
  // succeeds only if an entry is popped in the same cycle.
  always_comb begin
    fifo_full  = (count_q == CW'(FIFO_DEPTH));
    fifo_pop   = (count_q != '0) && ascii_ready;
    fifo_wr    = char_valid_q && (!fifo_full || fifo_pop);
    wr_ptr_d   = fifo_wr  ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = fifo_pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (fifo_wr && !fifo_pop)      count_d = count_q + CW'(1);
    else if (!fifo_wr && fifo_pop) count_d = count_q - CW'(1);
    overflow_d = overflow_q;
    if (char_valid_q && fifo_full && !fifo_pop) overflow_d = 1'b1;
    else if (clear_overflow)                    overflow_d = 1'b0;
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      lshift_q     <= 1'b0;
      rshift_q     <= 1'b0;
      lctrl_q      <= 1'b0;
      rctrl_q      <= 1'b0;
      caps_q       <= 1'b0;
      caps_held_q  <= 1'b0;
      char_valid_q <= 1'b0;
      char_q       <= 8'h00;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q      <= state_d;
      lshift_q     <= lshift_d;
      rshift_q     <= rshift_d;
      lctrl_q      <= lctrl_d;
      rctrl_q      <= rctrl_d;
      caps_q       <= caps_d;
      caps_held_q  <= caps_held_d;
      char_valid_q <= char_valid_d;
      char_q       <= char_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
    end
  end

  // FIFO storage write port.
  // NOTE: the storage array has no reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= char_q;
  end

  assign ascii_valid = (count_q != '0);
  assign ascii_data  = ascii_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;
  assign shift_state = shift_any;
  assign ctrl_state  = ctrl_any;
  assign caps_state  = caps_q;

endmodule

// File: tb/tb_kb_scan_to_ascii_fifo.sv
// Scoreboard bench for kb_scan_to_ascii_fifo. The stimulus pushes the
// hand-computed characters it expects. A negedge monitor pops and compares
// every character that the DUT hands over.
module tb_kb_scan_to_ascii_fifo;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          scan_valid = 1'b0;
  logic [7:0]    scan_code = 8'h00;
  logic          ascii_ready = 1'b1;
  logic          clear_overflow = 1'b0;
  logic          ascii_valid;
  logic [7:0]    ascii_data;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          shift_state;
  logic          ctrl_state;
  logic          caps_state;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];

  kb_scan_to_ascii_fifo #(
    .FIFO_DEPTH  (DEPTH),
    .CAPS_SYMBOLS(1'b0),
    .CTRL_EN     (1'b1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .scan_valid    (scan_valid),
    .scan_code     (scan_code),
    .ascii_ready   (ascii_ready),
    .clear_overflow(clear_overflow),
    .ascii_valid   (ascii_valid),
    .ascii_data    (ascii_data),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .shift_state   (shift_state),
    .ctrl_state    (ctrl_state),
    .caps_state    (caps_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every handshake must match the oldest expected character.
  always @(negedge clk) begin
    if (rst_n && ascii_valid && ascii_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_char: got %0h expected none", ascii_data);
      end else begin
        check("char", {24'h0, ascii_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // All tasks start and end at posedge + 1.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    scan_valid = 1'b1;
    scan_code  = c;
    cycle();
    scan_valid = 1'b0;
  endtask

  task automatic send_exp(input logic [7:0] c, input logic [7:0] e);
    exp_q.push_back(e);
    send(c);
  endtask

  // Wait (bounded) until every expected character has been consumed.
  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ascii_valid) && n < 200) begin
      cycle();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  logic [7:0] fill_codes [DEPTH];

  initial begin
    fill_codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                   8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();

    // Reset state
    check("rst_valid", ascii_valid, 0);
    check("rst_data", ascii_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_shift", shift_state, 0);
    check("rst_ctrl", ctrl_state, 0);
    check("rst_caps", caps_state, 0);

    // 1: plain make, then break emits nothing
    send_exp(8'h1C, 8'h61);
    send(8'hF0); send(8'h1C);
    repeat (4) cycle();
    check("t1_count", fifo_count, 0);
    drain("t1_drain");

    // 2: shift make/break
    send(8'h12);
    check("t2_shift_on", shift_state, 1);
    send_exp(8'h1C, 8'h41);
    send(8'hF0); send(8'h12);
    check("t2_shift_off", shift_state, 0);
    send_exp(8'h1C, 8'h61);
    drain("t2_drain");

    // 3: caps with typematic repeats, caps on letters only
    send(8'h58); send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
    check("t3_caps_on", caps_state, 1);
    send_exp(8'h1C, 8'h41);
    send(8'h12);
    send_exp(8'h16, 8'h21);
    send_exp(8'h1C, 8'h61);   // shift XOR caps -> lower case
    send(8'hF0); send(8'h12);
    send(8'h58); send(8'hF0); send(8'h58);
    check("t3_caps_off", caps_state, 0);
    drain("t3_drain");

    // 4: ctrl codes, extended keys, unmapped code
    send(8'h14);
    check("t4_lctrl_on", ctrl_state, 1);
    send_exp(8'h21, 8'h03);
    send(8'hF0); send(8'h14);
    check("t4_lctrl_off", ctrl_state, 0);
    send(8'hE0); send(8'h14);
    check("t4_rctrl_on", ctrl_state, 1);
    send(8'hE0); send(8'hF0); send(8'h14);
    check("t4_rctrl_off", ctrl_state, 0);
    send(8'hE0); exp_q.push_back(8'h0A); send(8'h5A);
    send(8'hE0); send(8'h75);
    send(8'h07);
    send(8'hE0); exp_q.push_back(8'h2F); send(8'h4A);
    send(8'h12);
    send_exp(8'h0D, 8'h09);
    send(8'hF0); send(8'h12);
    drain("t4_drain");

    // 5: overflow with ready low, then drain and clear
    ascii_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (i < DEPTH) exp_q.push_back(8'h20);
      send(8'h29);
    end
    repeat (3) cycle();
    check("t5_count_full", fifo_count, DEPTH);
    check("t5_overflow", overflow, 1);
    ascii_ready = 1'b1;
    drain("t5_drain");
    check("t5_overflow_sticky", overflow, 1);
    clear_overflow = 1'b1;
    cycle();
    clear_overflow = 1'b0;
    check("t5_overflow_clr", overflow, 0);

    // 6: full FIFO with simultaneous push and pop
    ascii_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_exp(fill_codes[i], 8'h61 + 8'(i));
    send_exp(8'h15, 8'h71);
    ascii_ready = 1'b1;       // pop on the same edge that writes 'q'
    cycle();
    ascii_ready = 1'b0;
    check("t6_count_kept", fifo_count, DEPTH);
    check("t6_no_overflow", overflow, 0);
    ascii_ready = 1'b1;
    drain("t6_drain");

    // Reset in the middle of a break prefix
    send(8'h12);
    send(8'hF0);
    rst_n = 1'b0;
    cycle();
    check("t6_rst_valid", ascii_valid, 0);
    check("t6_rst_count", fifo_count, 0);
    check("t6_rst_shift", shift_state, 0);
    rst_n = 1'b1;
    cycle();
    send_exp(8'h1C, 8'h61);
    drain("t6_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
